ysyx_22040750_axi_rd_slave: RTL

//   AXI4 read responder (slave) serving the icache/dcache read master. Accepts one AR burst at a

---
 rtl/ysyx_22040750_axi_rd_slave.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_22040750_axi_rd_slave.sv
// ysyx_22040750_axi_rd_slave
//   AXI4 read responder for the icache/dcache read master. Accepts one AR
//   burst at a time, reads the backing 64-bit RAM one beat per cycle and
//   returns R beats through a 2-entry FIFO so that I_rready backpressure
//   does not cost throughput.
//
// Optional feature macro: YSYX_22040750_AXI_RD_WRAP_EN
//   defined   : WRAP bursts wrap at (arlen+1)<<arsize; a WRAP with arlen not
//               in {1,3,7,15} is answered with SLVERR beats.
//   undefined : arburst=WRAP behaves exactly like INCR.
//
// Ports
//   I_clk, I_rst       clock, synchronous active-high reset
//   I_ar*, O_arready   AR channel (address, len, size, burst, valid/ready)
//   O_r*, I_rready     R channel (data, resp, last, valid/ready)
//   O_ram_addr         8-byte aligned RAM word address
//   O_ram_ren          RAM read strobe
//   I_ram_rdata        RAM data, valid the cycle after O_ram_ren
module ysyx_22040750_axi_rd_slave #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
) (
  input  logic              I_clk,
  input  logic              I_rst,
  input  logic [ADDR_W-1:0] I_araddr,
  input  logic [7:0]        I_arlen,
  input  logic [2:0]        I_arsize,
  input  logic [1:0]        I_arburst,
  input  logic              I_arvalid,
  output logic              O_arready,
  output logic [DATA_W-1:0] O_rdata,
  output logic [1:0]        O_rresp,
  output logic              O_rlast,
  output logic              O_rvalid,
  input  logic              I_rready,
  output logic [ADDR_W-1:0] O_ram_addr,
  output logic              O_ram_ren,
  input  logic [DATA_W-1:0] I_ram_rdata
);

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic              arready_q;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        beat_cnt;
  logic [2:0]        size;
  logic [1:0]        burst;
  logic              err;

  logic              inflight;
  logic              inflight_last;
  logic              inflight_err;

  logic [DATA_W-1:0] fifo_data [2];
  logic [1:0]        fifo_resp [2];
  logic              fifo_last [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        fifo_cnt;

  logic              ar_fire;
  logic              ar_err;
  logic              pop;
  logic              issue;
  logic [2:0]        occ;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] next_addr;

`ifdef YSYX_22040750_AXI_RD_WRAP_EN
  logic [7:0]        len;
  logic [ADDR_W-1:0] wrap_mask;

  assign wrap_mask = (({{(ADDR_W-8){1'b0}}, len} + ADDR_ONE) << size) - ADDR_ONE;
`endif

  assign O_arready  = arready_q;
  assign O_rvalid   = (fifo_cnt != 2'd0);
  assign O_rdata    = fifo_data[rd_ptr];
  assign O_rresp    = fifo_resp[rd_ptr];
  assign O_rlast    = fifo_last[rd_ptr];
  assign pop        = O_rvalid && I_rready;
  assign ar_fire    = I_arvalid && arready_q;

  // A beat may only be issued if, counting the beat still in the RAM
  // pipeline and the pop happening this cycle, the FIFO keeps a free slot.
  // This has to look at I_rready combinationally to sustain one beat/cycle.
  assign occ        = {1'b0, fifo_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == BURST) && (occ < 3'd2);
  assign O_ram_ren  = issue && !err;
  assign O_ram_addr = {addr[ADDR_W-1:3], 3'b000};

  assign step       = ADDR_ONE << size;
  assign incr_addr  = addr + step;

  // Address of the next beat: FIXED stays put, INCR steps by the beat size,
  // WRAP (when enabled) keeps the bits above the wrap window and lets only
  // the bits inside it roll over.
  always_comb begin
    next_addr = incr_addr;
    if (burst == 2'b00) begin
      next_addr = addr;
    end
`ifdef YSYX_22040750_AXI_RD_WRAP_EN
    else if (burst == 2'b10) begin
      next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
    end
`endif
  end

  // Bursts we cannot serve are still answered beat for beat, but with
  // SLVERR and without touching the RAM.
  always_comb begin
    ar_err = (I_arsize > 3'd3);
`ifdef YSYX_22040750_AXI_RD_WRAP_EN
    if ((I_arburst == 2'b10) &&
        !((I_arlen == 8'd1) || (I_arlen == 8'd3) ||
          (I_arlen == 8'd7) || (I_arlen == 8'd15))) begin
      ar_err = 1'b1;
    end
`endif
  end

  // Burst control: latch the AR request, issue beats in order, then wait
  // for the last beat to leave the FIFO before taking the next request.
  // The RAM pipeline stage (inflight) remembers whether the beat it carries
  // is the last one and whether it is an error beat.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state         <= IDLE;
      arready_q     <= 1'b0;
      addr          <= '0;
      beat_cnt      <= 8'd0;
      size          <= 3'd0;
      burst         <= 2'b00;
      err           <= 1'b0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      inflight_err  <= 1'b0;
`ifdef YSYX_22040750_AXI_RD_WRAP_EN
      len           <= 8'd0;
`endif
    end else begin
      inflight      <= issue;
      inflight_last <= issue && (beat_cnt == 8'd0);
      inflight_err  <= err;
      case (state)
        IDLE: begin
          if (ar_fire) begin
            addr      <= I_araddr;
            beat_cnt  <= I_arlen;
            size      <= I_arsize;
            burst     <= I_arburst;
            err       <= ar_err;
`ifdef YSYX_22040750_AXI_RD_WRAP_EN
            len       <= I_arlen;
`endif
            arready_q <= 1'b0;
            state     <= BURST;
          end else begin
            arready_q <= 1'b1;
          end
        end
        BURST: begin
          if (issue) begin
            addr <= next_addr;
            if (beat_cnt == 8'd0) begin
              state <= DRAIN;
            end else begin
              beat_cnt <= beat_cnt - 8'd1;
            end
          end
        end
        DRAIN: begin
          if (pop && O_rlast) begin
            state     <= IDLE;
            arready_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Two-entry R FIFO. Every beat that left the issue stage last cycle is
  // pushed now; the head drives the R channel and is held until popped.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      fifo_cnt <= 2'd0;
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_resp[i] <= 2'b00;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= inflight_err ? '0 : I_ram_rdata;
        fifo_resp[wr_ptr] <= inflight_err ? 2'b10 : 2'b00;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_cnt <= fifo_cnt + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
